updown_counter_param: RTL
=========================

// Module: updown_counter_param
// PURPOSE
//  Parametrised up/down counter with configurable width, modulus, synchronous load
//  and a per-cycle wrap/saturate mode select.
//  Registered terminal-count pulse for chaining into cascaded counters and timers.
//  General counting primitive for the exercise designs; supersedes the fixed 8-bit
//  up/down counter.
// PARAMETERS
//  WIDTH        8              counter width in bits, >= 1
//  MAX_COUNT    (1<<WIDTH)-1   top of count range 0..MAX_COUNT; must be < 2**WIDTH
//  RESET_VALUE  0              value loaded by rst; must be <= MAX_COUNT
//  PRESCALE     4              enabled cycles per count step; used only with
//                              COUNTER_PRESCALE_EN; >= 1
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      reset, synchronous, active-high
//  enable       in   1      count-step request for this cycle
//  direction    in   1      1 = up, 0 = down; sampled every cycle
//  sat_mode     in   1      1 = saturate at range ends, 0 = wrap; sampled every cycle
//  load         in   1      synchronous load strobe
//  load_value   in   WIDTH  value to load
//  counter_out  out  WIDTH  registered count
//  tc           out  1      registered one-cycle pulse on a boundary step
//  at_min       out  1      combinational: counter_out == 0
//  at_max       out  1      combinational: counter_out == MAX_COUNT
// BEHAVIOUR
//  - All state updates on rising clk. Priority: rst > load > enable.
//  - rst: counter_out <= RESET_VALUE; tc <= 0; prescaler <= 0.
//    Overrides load and enable in the same cycle, including mid-count.
//  - load: counter_out <= min(load_value, MAX_COUNT), so values above MAX_COUNT
//    clamp to MAX_COUNT.
//    tc <= 0; prescaler <= 0; enable is ignored that cycle.
//  - Step (enable=1, no rst/load, prescale condition met). Latency: 1 cycle.
//    - up,   counter <  MAX_COUNT: counter+1; tc <= 0
//    - up,   counter == MAX_COUNT: wrap -> 0, or saturate -> hold MAX_COUNT; tc <= 1
//    - down, counter >  0:         counter-1; tc <= 0
//    - down, counter == 0:         wrap -> MAX_COUNT, or saturate -> hold 0; tc <= 1
//  - tc pulses on every boundary step attempt, wrap or saturate. Consecutive
//    saturated attempts give consecutive tc=1 cycles.
//  - No step (enable=0, or prescale not met): counter holds; tc <= 0.
//  - Changes to direction or sat_mode take effect at the next edge. No pipeline,
//    no hysteresis.
//  - Next-value arithmetic is computed at WIDTH+1 bits, so MAX_COUNT = 2**WIDTH-1
//    cannot overflow silently.
//  - counter_out never leaves 0..MAX_COUNT.
// CONFIGURATION
//  Macro COUNTER_PRESCALE_EN:
//  - Defined:
//    - internal prescaler of $clog2(PRESCALE) bits (min 1) counts enabled cycles.
//    - A step occurs only on the enabled cycle where the prescaler == PRESCALE-1;
//      the prescaler then returns to 0.
//    - enable=0 holds the prescaler.
//    - rst and load clear the prescaler.
//    - tc evaluates only on steps that occur.
//  - Undefined: no prescaler logic; every enabled cycle is a step; PRESCALE is
//    ignored.
// TESTING (bench: WIDTH=4, MAX_COUNT=9, RESET_VALUE=0, PRESCALE=3)
//  1. rst=1 for 2 cycles with enable=1, load=1, load_value=7
//     -> counter_out=0, tc=0, at_min=1 after each edge.
//  2. Up wrap from 0: enable=1, direction=1, sat_mode=0, 10 cycles
//     -> counter_out 1..9 then 0; tc=1 only in the cycle counter_out becomes 0.
//  3. Down saturate: load 2, then direction=0, sat_mode=1, enable=1, 4 cycles
//     -> counter_out 1,0,0,0; tc=0,0,1,1.
//  4. Load clamp/priority: counter_out=4, load=1, load_value=13, enable=1
//     -> counter_out=9, at_max=1, tc=0.
//  5. Reset mid-count: counter_out=5, rst=1 and load=1 same cycle
//     -> counter_out=0; next cycle with enable=1 up -> counter_out=1.
//  6. Prescale: from 0, enable=1 up for 9 cycles
//     -> with COUNTER_PRESCALE_EN counter_out=3 (steps on cycles 3,6,9); without it
//        counter_out=9.
//     Then 1 idle cycle: prescaler and counter hold.

Source files
------------

// File: rtl/updown_counter_param.sv
// updown_counter_param: parametrised up/down counter over the range 0..MAX_COUNT.
// Synchronous load (clamped to MAX_COUNT), per-cycle wrap/saturate select, and a
// registered terminal-count pulse on every boundary step for chaining counters.
// at_min / at_max are combinational decodes of the registered count.
//
// Optional feature macro: COUNTER_PRESCALE_EN
//   Defined   : a prescaler counts enabled cycles and a step happens only on
//               every PRESCALE-th enabled cycle.
//   Undefined : every enabled cycle is a step and PRESCALE is ignored.

module updown_counter_param #(
    parameter int WIDTH       = 8,
    parameter int MAX_COUNT   = (1 << WIDTH) - 1,
    parameter int RESET_VALUE = 0,
    parameter int PRESCALE    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             direction,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter_out,
    output logic             tc,
    output logic             at_min,
    output logic             at_max
);

    // Range ends held one bit wider so MAX_COUNT = 2**WIDTH-1 compares cleanly.
    localparam logic [WIDTH:0]   MAX_EXT_C = (WIDTH + 1)'(MAX_COUNT);
    localparam logic [WIDTH-1:0] MAX_VAL_C = MAX_EXT_C[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESET_C   = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH:0]   ONE_EXT_C = (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] ZERO_C    = {WIDTH{1'b0}};

    // Reject parameter sets that would let the count leave its legal range.
    if ((WIDTH < 1) || (PRESCALE < 1) || (MAX_COUNT < 0) ||
        (MAX_COUNT > ((1 << WIDTH) - 1)) ||
        (RESET_VALUE < 0) || (RESET_VALUE > MAX_COUNT)) begin : g_bad_params
        $error("updown_counter_param: illegal parameter combination");
    end

    // Clamp a load value into 0..MAX_COUNT.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] value);
        logic [WIDTH-1:0] result;
        if ({1'b0, value} > MAX_EXT_C) begin
            result = MAX_VAL_C;
        end else begin
            result = value;
        end
        return result;
    endfunction

    logic [WIDTH:0]   count_ext_s;
    logic [WIDTH:0]   inc_ext_s;
    logic [WIDTH:0]   dec_ext_s;
    logic             step_s;
    logic [WIDTH-1:0] next_count_s;
    logic             next_tc_s;

`ifdef COUNTER_PRESCALE_EN
    localparam int            PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST_C = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] PS_ZERO_C = {PS_W{1'b0}};
    localparam logic [PS_W-1:0] PS_ONE_C  = PS_W'(1);

    logic [PS_W-1:0] prescale_r;

    // A step is granted only on the enabled cycle that completes a prescale period.
    always_comb begin
        step_s = enable && (prescale_r == PS_LAST_C);
    end

    // Prescaler counts enabled cycles; rst and load restart the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_r <= PS_ZERO_C;
        end else if (load) begin
            prescale_r <= PS_ZERO_C;
        end else if (enable) begin
            if (prescale_r == PS_LAST_C) begin
                prescale_r <= PS_ZERO_C;
            end else begin
                prescale_r <= prescale_r + PS_ONE_C;
            end
        end else begin
            prescale_r <= prescale_r;
        end
    end
`else
    // Without the prescaler every enabled cycle is a step.
    always_comb begin
        step_s = enable;
    end
`endif

    // Widened neighbours of the current count; only used away from the range ends.
    always_comb begin
        count_ext_s = {1'b0, counter_out};
        inc_ext_s   = count_ext_s + ONE_EXT_C;
        dec_ext_s   = count_ext_s - ONE_EXT_C;
    end

    // Next count and terminal-count decision; load outranks a step.
    always_comb begin
        next_count_s = counter_out;
        next_tc_s    = 1'b0;
        if (load) begin
            next_count_s = clamp_load(load_value);
            next_tc_s    = 1'b0;
        end else if (step_s) begin
            if (direction) begin
                if (count_ext_s >= MAX_EXT_C) begin
                    next_count_s = sat_mode ? MAX_VAL_C : ZERO_C;
                    next_tc_s    = 1'b1;
                end else begin
                    next_count_s = inc_ext_s[WIDTH-1:0];
                    next_tc_s    = 1'b0;
                end
            end else begin
                if (counter_out == ZERO_C) begin
                    next_count_s = sat_mode ? ZERO_C : MAX_VAL_C;
                    next_tc_s    = 1'b1;
                end else begin
                    next_count_s = dec_ext_s[WIDTH-1:0];
                    next_tc_s    = 1'b0;
                end
            end
        end else begin
            next_count_s = counter_out;
            next_tc_s    = 1'b0;
        end
    end

    // Count and terminal-count registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_out <= RESET_C;
            tc          <= 1'b0;
        end else begin
            counter_out <= next_count_s;
            tc          <= next_tc_s;
        end
    end

    // Range-end flags decoded from the registered count.
    always_comb begin
        at_min = (counter_out == ZERO_C);
        at_max = (counter_out == MAX_VAL_C);
    end

endmodule
